// File: rtl/polaris_dbridge.sv
// polaris_dbridge: narrows one 64-bit-addressed CPU load/store (byte..dword) into
// 1, 2 or 4 little-endian 16-bit Wishbone-classic beats, assembles and extends read
// data, and returns a single-cycle acknowledge. All outputs come straight from flops.
module polaris_dbridge #(
  parameter int unsigned AW = 24
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          dcyc_i,
  input  logic          dstb_i,
  input  logic          dwe_i,
  input  logic [1:0]    dsiz_i,
  input  logic          dsigned_i,
  input  logic [63:0]   dadr_i,
  input  logic [63:0]   ddat_i,
  output logic          dack_o,
  output logic [63:0]   ddat_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [1:0]    wb_sel_o,
  output logic [AW-2:0] wb_adr_o,
  output logic [15:0]   wb_dat_o,
  input  logic [15:0]   wb_dat_i,
  input  logic          wb_ack_i
);

  typedef enum logic [1:0] {StIdle, StBeat, StAck} state_e;

  state_e          state_q, state_d;
  logic            we_q, we_d;
  logic [1:0]      siz_q, siz_d;
  logic            sgn_q, sgn_d;
  logic            lane_q, lane_d;
  logic [AW-2:0]   base_q, base_d;
  logic [63:0]     dat_q, dat_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [63:0]     asm_q, asm_d;
  logic            last_beat;

  logic            dack_d, stb_d, wwe_d;
  logic [1:0]      sel_d;
  logic [AW-2:0]   adr_d;
  logic [15:0]     wdat_d;
  logic [63:0]     ddat_d;

  // Address bits above the external bus width are not routed anywhere.
  logic unused_adr;
  assign unused_adr = ^dadr_i[63:AW];

  function automatic logic [63:0] extend(input logic [63:0] v, input logic [1:0] siz,
                                         input logic sgn);
    unique case (siz)
      2'b00:   extend = {{56{sgn & v[7]}}, v[7:0]};
      2'b01:   extend = {{48{sgn & v[15]}}, v[15:0]};
      2'b10:   extend = {{32{sgn & v[31]}}, v[31:0]};
      default: extend = v;
    endcase
  endfunction

  // Next-state logic; bus outputs are computed for the cycle about to start.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    siz_d   = siz_q;
    sgn_d   = sgn_q;
    lane_d  = lane_q;
    base_d  = base_q;
    dat_d   = dat_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    ddat_d  = dack_o ? ddat_o : ddat_o;
    dack_d  = 1'b0;
    stb_d   = 1'b0;
    wwe_d   = 1'b0;
    sel_d   = 2'b00;
    adr_d   = '0;
    wdat_d  = '0;

    unique case (siz_q)
      2'b10:   last_beat = (cnt_q == 2'd1);
      2'b11:   last_beat = (cnt_q == 2'd3);
      default: last_beat = 1'b1;
    endcase

    unique case (state_q)
      StIdle: begin
        if (dcyc_i && dstb_i) begin
          we_d   = dwe_i;
          siz_d  = dsiz_i;
          sgn_d  = dsigned_i;
          dat_d  = ddat_i;
          lane_d = dadr_i[0];
          // Force natural alignment of the half-word base for word and dword.
          case (dsiz_i)
            2'b10:   base_d = {dadr_i[AW-1:2], 1'b0};
            2'b11:   base_d = {dadr_i[AW-1:3], 2'b00};
            default: base_d = dadr_i[AW-1:1];
          endcase
          cnt_d   = 2'd0;
          asm_d   = '0;
          state_d = StBeat;
        end
      end
      StBeat: begin
        if (wb_ack_i) begin
          if (!we_q) begin
            if (siz_q == 2'b00) asm_d[7:0] = lane_q ? wb_dat_i[15:8] : wb_dat_i[7:0];
            else                asm_d[{cnt_q, 4'b0000} +: 16] = wb_dat_i;
          end
          cnt_d = cnt_q + 2'd1;
          if (last_beat) begin
            state_d = StAck;
            dack_d  = 1'b1;
            ddat_d  = we_q ? 64'd0 : extend(asm_d, siz_q, sgn_q);
          end
        end
      end
      // The ACK cycle swallows a still-asserted CPU strobe.
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (state_d == StBeat) begin
      stb_d  = 1'b1;
      wwe_d  = we_d;
      sel_d  = (siz_d == 2'b00) ? (lane_d ? 2'b10 : 2'b01) : 2'b11;
      adr_d  = base_d + (AW-1)'(cnt_d);
      wdat_d = (siz_d == 2'b00) ? {2{dat_d[7:0]}} : dat_d[{cnt_d, 4'b0000} +: 16];
    end
  end

  // State, captured request and registered outputs; reset aborts any transfer.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      siz_q    <= 2'b00;
      sgn_q    <= 1'b0;
      lane_q   <= 1'b0;
      base_q   <= '0;
      dat_q    <= '0;
      cnt_q    <= 2'd0;
      asm_q    <= '0;
      dack_o   <= 1'b0;
      ddat_o   <= '0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_sel_o <= 2'b00;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      siz_q    <= siz_d;
      sgn_q    <= sgn_d;
      lane_q   <= lane_d;
      base_q   <= base_d;
      dat_q    <= dat_d;
      cnt_q    <= cnt_d;
      asm_q    <= asm_d;
      dack_o   <= dack_d;
      ddat_o   <= ddat_d;
      wb_cyc_o <= stb_d;
      wb_stb_o <= stb_d;
      wb_we_o  <= wwe_d;
      wb_sel_o <= sel_d;
      wb_adr_o <= adr_d;
      wb_dat_o <= wdat_d;
    end
  end

endmodule
